// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the SRAM subordinate and its environment.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not.
   function automatic logic htrans_active(input logic [1:0] htrans);
      return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_sram_subordinate_if.sv
// AHB-Lite bus bundle between one manager and the SRAM subordinate.
interface ahb_sram_subordinate_if;

   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [3:0]  HWSTRB;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HWSTRB, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );

endinterface

// File: rtl/ahb_sub_mem.sv
// Flop-based word memory: byte-strobed synchronous write, combinational read, no reset.
module ahb_sub_mem #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic                           clk_i,
   input  logic                           we_i,
   input  logic [3:0]                     strb_i,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
   input  logic [31:0]                    wdata_i,
   output logic [31:0]                    rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (strb_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite single-beat word subordinate backed by a local flop memory, with
// programmable wait states. Define AHB_SUB_RANGE_ERR_EN to enable ERROR responses.
module ahb_sram_subordinate
   import ahb_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   ahb_sram_subordinate_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t           state_q;
   logic [2:0]       cnt_q;
   logic             act_q;
   logic             write_q;
   logic [IDX_W-1:0] idx_q;
   logic             hready_q;
   logic             hresp_q;

   logic [31:0]      offset;
   logic [IDX_W-1:0] idx_d;
   logic             accept;
   logic             legal;
   logic             complete;
   logic             mem_we;
   logic [31:0]      mem_rdata;

   // Borrow/carry of the base subtraction is dropped so out-of-window
   // addresses alias modulo the memory size.
   assign offset = bus.HADDR - BASE_ADDR;
   assign idx_d  = offset[IDX_W+1:2];
   assign accept = bus.HSEL && htrans_active(bus.HTRANS) && bus.HREADY;

`ifdef AHB_SUB_RANGE_ERR_EN
   assign legal = (offset < 32'(DEPTH_WORDS * 4)) &&
                  (bus.HADDR[1:0] == 2'b00) &&
                  (bus.HSIZE == HSIZE_WORD);
`else
   assign legal = 1'b1;
`endif

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         act_q    <= 1'b0;
         write_q  <= 1'b0;
         idx_q    <= '0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_ERR2: begin
               state_q  <= ST_IDLE;
               act_q    <= 1'b0;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_OKAY;
               if (accept) begin
                  write_q <= bus.HWRITE;
                  idx_q   <= idx_d;
                  if (!legal) begin
                     state_q  <= ST_ERR1;
                     hready_q <= 1'b0;
                     hresp_q  <= HRESP_ERROR;
                  end else begin
                     act_q <= 1'b1;
                     if (WAIT_STATES > 0) begin
                        state_q  <= ST_WAIT;
                        cnt_q    <= 3'(WAIT_STATES);
                        hready_q <= 1'b0;
                     end
                  end
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_q  <= ST_IDLE;
                  hready_q <= 1'b1;
               end
            end
            // HRESP stays at ERROR into the second, ready cycle of the pair.
            ST_ERR1: begin
               state_q  <= ST_ERR2;
               hready_q <= 1'b1;
            end
            default: begin
               state_q  <= ST_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_OKAY;
            end
         endcase
      end
   end

   // act_q only survives into a ready cycle for a legal transfer, so this
   // is exactly the OKAY data-phase cycle.
   assign complete = act_q && hready_q;
   assign mem_we   = complete && write_q;

   ahb_sub_mem #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_mem (
      .clk_i   (HCLK),
      .we_i    (mem_we),
      .strb_i  (bus.HWSTRB),
      .addr_i  (idx_q),
      .wdata_i (bus.HWDATA),
      .rdata_o (mem_rdata)
   );

   assign bus.HREADYOUT = hready_q;
   assign bus.HRDATA    = (complete && !write_q) ? mem_rdata : 32'h0;

`ifdef AHB_SUB_RANGE_ERR_EN
   assign bus.HRESP = hresp_q;

   logic unused_bits;
   assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};
`else
   assign bus.HRESP = HRESP_OKAY;

   logic unused_bits;
   assign unused_bits = ^{hresp_q, offset[31:IDX_W+2], offset[1:0],
                          bus.HSIZE, bus.HBURST, bus.HTRANS[0]};
`endif

endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

AHB-Lite subordinate that sits directly downstream of the AHB manager and terminates its single-beat word transfers in a local flop-based memory. It decodes address-phase signals, inserts a programmable number of wait states, commits byte-strobed writes, returns read data, and optionally issues the two-cycle AHB ERROR response for illegal accesses. It is the default bench/target subordinate for the bus-protocol-to-AHB path.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; power of two, 16..1024.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: wait cycles inserted per OKAY transfer, 0..7.

Ports:
- HCLK  in  1  clock; all state changes on its rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  subordinate select.
- HADDR  in  32  byte address.
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ per ahb_pkg).
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; only WORD is legal.
- HBURST  in  3  ignored; single beats only.
- HWDATA  in  32  write data, data phase.
- HWSTRB  in  4  byte strobes, data phase.
- HREADY  in  1  bus-level ready; qualifies address-phase sampling.
- HREADYOUT  out  1  subordinate ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

## Operation
- Accept: transfer accepted on a rising edge where HSEL && HTRANS[1] && HREADY. HADDR, HWRITE, HSIZE captured into data-phase registers. IDLE/BUSY or HSEL=0 → no access, zero-wait OKAY.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On accept: legal → WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES), else remains in IDLE with data phase completing next cycle; illegal (with macro) → ERR1.
  - WAIT: HREADYOUT=0; counter decrements; at counter==1 → IDLE (data phase completes in following cycle).
  - ERR1: HREADYOUT=0, HRESP=1; → ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=1; → IDLE, or accepts a new transfer like IDLE.
- Completion cycle = data-phase cycle with HREADYOUT=1 and HRESP=0.
  - Write: at end of completion cycle, byte i of word (addr-BASE_ADDR)>>2 updated from HWDATA[8i+7:8i] where HWSTRB[i]=1.
  - Read: HRDATA = array[captured index], combinational from registered index, valid in completion cycle; 0 in all other cycles.
- Index arithmetic: (HADDR - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; carry/borrow discarded.
- Errored transfers: no memory write, HRDATA=0.
- Back-to-back: write at cycle N followed by read of same word accepted in cycle N returns new data in cycle N+1.

## Timing
- Reset: state IDLE, counter 0, data-phase registers 0, HREADYOUT=1, HRESP=0, HRDATA=0. Memory contents not cleared. Reset asserted mid-WAIT/ERR1 aborts the transfer: no write, IDLE next cycle.
- Latency: completion 1+WAIT_STATES cycles after accept edge. Error: ERR1 in first data-phase cycle regardless of WAIT_STATES, ERR2 next.
- Address phase presented while HREADYOUT=0 is not sampled (HREADY low).
- HRESP never changes while HREADYOUT=0 except entering ERR1.

## Configuration
- AHB_SUB_RANGE_ERR_EN defined: illegal = address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4), HADDR[1:0]!=0, or HSIZE!=WORD; illegal → ERR1/ERR2.
- Undefined: no ERROR response ever; HRESP tied 0; out-of-range addresses alias modulo DEPTH_WORDS, HADDR[1:0] and HSIZE ignored; ERR1/ERR2 unreachable.

## Structure
- ahb_pkg: HTRANS encodings, HSIZE WORD, HRESP OKAY/ERROR constants. Subordinate state enum stays local.
- Sub-module ahb_sub_mem: DEPTH_WORDS×32 flop array, 4-bit strobed synchronous write port, combinational read port; no reset.

## Test plan
- WAIT_STATES=0: write 32'hDEAD_BEEF to 0x10 strobe 4'hF, then read 0x10 → HREADYOUT high throughout, HRDATA=32'hDEAD_BEEF one cycle after read accept.
- Strobe 4'b0101 write 32'h1122_3344 over 32'hDEAD_BEEF → read returns 32'hDE22_BE44.
- WAIT_STATES=3: read → HREADYOUT low exactly 3 cycles, data in 4th data-phase cycle.
- Macro defined, DEPTH_WORDS=256, read 0x400 → ERR1 (HREADYOUT=0, HRESP=1), ERR2 (1,1), HRDATA=0; macro undefined → OKAY, aliases word 0.
- Macro defined, write to 0x02 → ERROR pair, word 0 unchanged.
- HRESET asserted in WAIT of a write → IDLE, HREADYOUT=1, target word unchanged.
